// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO for 16-bit ALU results
// (Z plus flags {S,ZR,CY,P,V}). It also keeps a sticky OR of every flag
// accepted since the last clear.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that side (push = in_valid & in_ready, pop = out_valid &
// out_ready). in_ready and out_valid depend only on registered occupancy, so
// a pop while full never frees space for a push in the same cycle. The
// producer holds Z and the flags stable while in_valid=1 and in_ready=0.
module alu_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           Z,
  input  logic                       S,
  input  logic                       ZR,
  input  logic                       CY,
  input  logic                       P,
  input  logic                       V,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_z,
  output logic [4:0]                 out_flags,
  output logic [4:0]                 sticky_flags,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 5;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    in_flags;
  logic          push;
  logic          pop;

  assign in_flags  = {S, ZR, CY, P, V};
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head entry falls through combinationally; zeroed while empty.
  always_comb begin
    out_z     = '0;
    out_flags = '0;
    if (out_valid) begin
      out_z     = mem[rd_ptr][EW-1:5];
      out_flags = mem[rd_ptr][4:0];
    end
  end

  // Storage array: written on push, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {Z, in_flags};
    end
  end

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky flags: clear takes priority, then the same-cycle push is ORed in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (clr_sticky) begin
      sticky_flags <= push ? in_flags : 5'b0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed scenarios plus a scoreboarded random stress
// for alu_result_fifo. Inputs change 1ns after the rising edge and outputs
// are sampled in the same window.
module tb_alu_result_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Z;
  logic        S, ZR, CY, P, V;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [4:0]  out_flags;
  logic [4:0]  sticky_flags;
  logic        clr_sticky;
  logic [2:0]  count;

  int checks;
  int failures;
  logic [20:0] exp_q[$];

  alu_result_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Z(Z), .S(S), .ZR(ZR), .CY(CY), .P(P), .V(V),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_flags(out_flags), .sticky_flags(sticky_flags),
    .clr_sticky(clr_sticky), .count(count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] z, input logic [4:0] f);
    Z = z;
    {S, ZR, CY, P, V} = f;
  endtask

  task automatic push_one(input logic [15:0] z, input logic [4:0] f);
    in_valid = 1'b1;
    set_in(z, f);
    step();
    in_valid = 1'b0;
  endtask

  // Checks the head against the scoreboard, then pops it.
  task automatic pop_check(input string name);
    logic [20:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if ({out_valid, out_z, out_flags} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL %s: got valid=%b z=%h flags=%b, required valid=1 z=%h flags=%b",
               name, out_valid, out_z, out_flags, exp[20:5], exp[4:0]);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checks++;
    if ({count, out_valid, in_ready, out_z, out_flags, sticky_flags} !==
        {3'd0, 1'b0, 1'b1, 16'h0, 5'h0, 5'h0}) begin
      failures++;
      $display("FAIL reset_initial: got count=%0d ov=%b ir=%b z=%h f=%b st=%b, required 0 0 1 0000 0 0",
               count, out_valid, in_ready, out_z, out_flags, sticky_flags);
    end
    push_one(16'h1111, 5'b10000);
    push_one(16'h2222, 5'b01000);
    push_one(16'h3333, 5'b00001);
    checks++;
    if (count !== 3'd3 || sticky_flags !== 5'b11001) begin
      failures++;
      $display("FAIL reset_burst: got count=%0d st=%b, required count=3 st=11001",
               count, sticky_flags);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, out_valid, in_ready, out_z, out_flags, sticky_flags} !==
        {3'd0, 1'b0, 1'b1, 16'h0, 5'h0, 5'h0}) begin
      failures++;
      $display("FAIL reset_async: got count=%0d ov=%b ir=%b z=%h f=%b st=%b, required 0 0 1 0000 0 0",
               count, out_valid, in_ready, out_z, out_flags, sticky_flags);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    push_one(16'h0FFF, 5'b00101);
    checks++;
    if ({out_valid, out_z, out_flags, count} !== {1'b1, 16'h0FFF, 5'b00101, 3'd1}) begin
      failures++;
      $display("FAIL single_head: got ov=%b z=%h f=%b count=%0d, required 1 0fff 00101 1",
               out_valid, out_z, out_flags, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({count, out_valid, out_z, out_flags} !== {3'd0, 1'b0, 16'h0, 5'h0}) begin
      failures++;
      $display("FAIL single_pop: got count=%0d ov=%b z=%h f=%b, required 0 0 0000 0",
               count, out_valid, out_z, out_flags);
    end
    // Pop while empty is ignored.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL pop_empty: got count=%0d ir=%b, required 0 1", count, in_ready);
    end
  endtask

  task automatic test_fill();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    checks++;
    if (sticky_flags !== 5'b0) begin
      failures++;
      $display("FAIL sticky_clr_alone: got %b, required 00000", sticky_flags);
    end
    push_one(16'h0FFF, 5'b00101); exp_q.push_back({16'h0FFF, 5'b00101});
    push_one(16'h0000, 5'b01100); exp_q.push_back({16'h0000, 5'b01100});
    push_one(16'hFFFF, 5'b10000); exp_q.push_back({16'hFFFF, 5'b10000});
    push_one(16'h1234, 5'b00000); exp_q.push_back({16'h1234, 5'b00000});
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_full: got count=%0d ir=%b ov=%b, required 4 0 1",
               count, in_ready, out_valid);
    end
    checks++;
    if (sticky_flags !== 5'b11101) begin
      failures++;
      $display("FAIL sticky_or: got %b, required 11101", sticky_flags);
    end
    push_one(16'hABCD, 5'b00010);
    checks++;
    if (count !== 3'd4 || sticky_flags !== 5'b11101) begin
      failures++;
      $display("FAIL push_full_ignored: got count=%0d st=%b, required 4 11101",
               count, sticky_flags);
    end
    for (int i = 0; i < 4; i++) pop_check("fill_drain");
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_empty: got count=%0d ov=%b, required 0 0", count, out_valid);
    end
  endtask

  task automatic test_sticky();
    clr_sticky = 1'b1;
    push_one(16'hFFFF, 5'b10000);
    clr_sticky = 1'b0;
    exp_q.push_back({16'hFFFF, 5'b10000});
    checks++;
    if (sticky_flags !== 5'b10000) begin
      failures++;
      $display("FAIL sticky_clr_push: got %b, required 10000", sticky_flags);
    end
    pop_check("sticky_drain");
  endtask

  task automatic test_back_to_back();
    logic [15:0] z;
    push_one(16'hA000, 5'b00001); exp_q.push_back({16'hA000, 5'b00001});
    push_one(16'hA001, 5'b00010); exp_q.push_back({16'hA001, 5'b00010});
    for (int i = 2; i < 10; i++) begin
      z = 16'hA000 + 16'(i);
      in_valid = 1'b1;
      set_in(z, 5'(i));
      exp_q.push_back({z, 5'(i)});
      pop_check("b2b_head");
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd2) begin
        failures++;
        $display("FAIL b2b_count: got %0d, required 2", count);
      end
    end
    pop_check("b2b_drain");
    pop_check("b2b_drain");
    // Full with pop and push offered together: only the pop is taken.
    for (int i = 0; i < 4; i++) begin
      z = 16'hC000 + 16'(i);
      push_one(z, 5'(i));
      exp_q.push_back({z, 5'(i)});
    end
    in_valid = 1'b1;
    set_in(16'hDEAD, 5'b11111);
    pop_check("full_pushpop_head");
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL full_pushpop_count: got %0d, required 3", count);
    end
    for (int i = 0; i < 3; i++) pop_check("full_pushpop_drain");
  endtask

  task automatic test_random();
    int          m_count;
    logic [4:0]  m_sticky;
    logic        push, pop;
    logic [20:0] exp;
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    m_count  = 0;
    m_sticky = 5'b0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      set_in(16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)));
      push = in_valid && (m_count != 4);
      pop  = out_ready && (m_count != 0);
      checks++;
      if (count !== 3'(m_count) || in_ready !== (m_count != 4) ||
          out_valid !== (m_count != 0) || sticky_flags !== m_sticky) begin
        failures++;
        $display("FAIL rand_state c=%0d: got count=%0d ir=%b ov=%b st=%b, required %0d %b %b %b",
                 c, count, in_ready, out_valid, sticky_flags, m_count,
                 (m_count != 4), (m_count != 0), m_sticky);
      end
      checks++;
      if (count > 3'd4 || (!out_valid && (out_z !== 16'h0 || out_flags !== 5'h0))) begin
        failures++;
        $display("FAIL rand_bounds c=%0d: got count=%0d ov=%b z=%h, required count<=4 and zero head when empty",
                 c, count, out_valid, out_z);
      end
      if (pop) begin
        exp = exp_q.pop_front();
        checks++;
        if ({out_z, out_flags} !== exp) begin
          failures++;
          $display("FAIL rand_data c=%0d: got z=%h f=%b, required z=%h f=%b",
                   c, out_z, out_flags, exp[20:5], exp[4:0]);
        end
      end
      if (push) begin
        exp_q.push_back({Z, S, ZR, CY, P, V});
        m_sticky = m_sticky | {S, ZR, CY, P, V};
      end
      m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Test sequence and final report
  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    set_in(16'h0, 5'h0);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_sticky();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
